// File: rtl/decode_instr_queue_if.sv
// Fetch/decode handshake bundle for the decode instruction queue.
// StallCntD only exists when DECQ_STALL_CNT_EN is defined.
// slave = queue side, master = fetch/decode (driver) side.
interface decode_instr_queue_if #(
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      InstrF;
  logic             InstrValidF;
  logic             InstrReadyF;
  logic             FlushD;
  logic             StallD;
  logic [31:0]      InstrD;
  logic [2:0]       ImmSrcD;
  logic             InstrValidD;
  logic [CNT_W-1:0] CountD;
`ifdef DECQ_STALL_CNT_EN
  logic [31:0]      StallCntD;

  modport slave (
    input  InstrF, InstrValidF, FlushD, StallD,
    output InstrReadyF, InstrD, ImmSrcD, InstrValidD, CountD, StallCntD
  );
  modport master (
    output InstrF, InstrValidF, FlushD, StallD,
    input  InstrReadyF, InstrD, ImmSrcD, InstrValidD, CountD, StallCntD
  );
`else
  modport slave (
    input  InstrF, InstrValidF, FlushD, StallD,
    output InstrReadyF, InstrD, ImmSrcD, InstrValidD, CountD
  );
  modport master (
    output InstrF, InstrValidF, FlushD, StallD,
    input  InstrReadyF, InstrD, ImmSrcD, InstrValidD, CountD
  );
`endif
endinterface

// File: rtl/decode_instr_queue.sv
// Purpose: fetch->decode instruction FIFO with immediate-format predecode at enqueue.
// Latency: 1 cycle (enqueued at edge N, visible on InstrD after edge N); no fall-through.
// Backpressure: InstrReadyF = registered count < DEPTH, no path from StallD; optional
// stall counter enabled by macro DECQ_STALL_CNT_EN.
module decode_instr_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOPINSTR = 32'h0000_0013
) (
  input  logic           clk,
  input  logic           reset_n,
  decode_instr_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      instr_mem_d [DEPTH];
  logic [2:0]       imm_mem_q   [DEPTH];
  logic [2:0]       imm_mem_d   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready;
  logic             valid;
  logic             enq;
  logic             deq;

  // Immediate format select from opcode/funct3; unknown opcodes fall back to I.
  function automatic logic [2:0] predecode(input logic [6:0] opcode, input logic [2:0] funct3);
    logic [2:0] fmt;
    fmt = 3'b000;
    case (opcode)
      7'b0000011, 7'b0000111, 7'b0010011,
      7'b0011011, 7'b1100111, 7'b1110011: fmt = 3'b000;
      7'b0100011, 7'b0100111:             fmt = 3'b001;
      7'b1100011:                         fmt = 3'b010;
      7'b1101111:                         fmt = 3'b011;
      7'b0110111, 7'b0010111:             fmt = 3'b100;
      7'b0101111:                         fmt = 3'b101;
      7'b0001111:                         fmt = (funct3 == 3'b010) ? 3'b101 : 3'b000;
      default:                            fmt = 3'b000;
    endcase
    return fmt;
  endfunction

  // Handshake terms come from registered occupancy only.
  always_comb begin
    ready = (count_q < DEPTH_C);
    valid = (count_q != '0);
    enq   = q.InstrValidF & ready;
    deq   = valid & ~q.StallD;
  end

  // Next-state: flush wins over everything, then independent enqueue/dequeue.
  always_comb begin
    instr_mem_d = instr_mem_q;
    imm_mem_d   = imm_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (q.FlushD) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        instr_mem_d[wr_ptr_q] = q.InstrF;
        imm_mem_d[wr_ptr_q]   = predecode(q.InstrF[6:0], q.InstrF[14:12]);
        wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state registers; reset discards every buffered entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= NOPINSTR;
        imm_mem_q[i]   <= 3'b000;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      instr_mem_q <= instr_mem_d;
      imm_mem_q   <= imm_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Head outputs are a mux on stored state; a NOP is presented while empty.
  assign q.InstrReadyF = ready;
  assign q.InstrValidD = valid;
  assign q.CountD      = count_q;
  assign q.InstrD      = valid ? instr_mem_q[rd_ptr_q] : NOPINSTR;
  assign q.ImmSrcD     = valid ? imm_mem_q[rd_ptr_q]   : 3'b000;

`ifdef DECQ_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where a valid head is held by decode; flush cycles excluded, wraps freely.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid && q.StallD && !q.FlushD) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign q.StallCntD = stall_cnt_q;
`endif

  // Occupancy must stay within [0, DEPTH].
  a_count_bound: assert property (@(posedge clk) disable iff (!reset_n) count_q <= DEPTH_C);
  a_count_next:  assert property (@(posedge clk) disable iff (!reset_n) count_d <= DEPTH_C);

endmodule

// File: tb/tb_decode_instr_queue.sv
// Self-checking bench for decode_instr_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_decode_instr_queue;
  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  decode_instr_queue_if #(.DEPTH(DEPTH)) bus();

  decode_instr_queue #(.DEPTH(DEPTH), .NOPINSTR(NOP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: list of buffered instructions (front = head) and stall count.
  logic [31:0] mq[$];
  logic [31:0] m_stall;

  function automatic logic [2:0] ref_fmt(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    if (op inside {7'b0100011, 7'b0100111}) return 3'b001;
    if (op == 7'b1100011) return 3'b010;
    if (op == 7'b1101111) return 3'b011;
    if (op inside {7'b0110111, 7'b0010111}) return 3'b100;
    if (op == 7'b0101111) return 3'b101;
    if (op == 7'b0001111 && ins[14:12] == 3'b010) return 3'b101;
    return 3'b000;
  endfunction

  task automatic set_in(input logic v, input logic [31:0] ins, input logic st, input logic fl);
    bus.InstrValidF = v;
    bus.InstrF      = ins;
    bus.StallD      = st;
    bus.FlushD      = fl;
  endtask

  // One clock edge; the model consumes the inputs that were present at the edge.
  task automatic cycle();
    bit enq, deq;
    @(posedge clk);
    if (bus.FlushD) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && bus.StallD) m_stall = m_stall + 32'd1;
      deq = (mq.size() > 0) && !bus.StallD;
      enq = bus.InstrValidF && (mq.size() < DEPTH);
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back(bus.InstrF);
    end
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    mq.delete();
    m_stall = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mq.delete();
    m_stall = '0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.InstrValidD !== 1'b0 || bus.InstrD !== NOP || bus.InstrReadyF !== 1'b1 ||
        bus.CountD !== CW'(0) || bus.ImmSrcD !== 3'b000) begin
      errors++;
      $display("FAIL reset_init: valid=%b instr=%h ready=%b count=%0d imm=%b want 0/00000013/1/0/000",
               bus.InstrValidD, bus.InstrD, bus.InstrReadyF, bus.CountD, bus.ImmSrcD);
    end
    reset_n = 1'b1;
    // Traffic, then async reset asserted between edges.
    set_in(1'b1, 32'h00A00093, 1'b1, 1'b0);
    cycle();
    set_in(1'b1, 32'h00112023, 1'b1, 1'b0);
    cycle();
    checks++;
    if (bus.CountD !== CW'(2)) begin
      errors++;
      $display("FAIL reset_prefill: count=%0d want 2", bus.CountD);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.InstrValidD !== 1'b0 || bus.InstrD !== NOP || bus.InstrReadyF !== 1'b1 ||
        bus.CountD !== CW'(0)) begin
      errors++;
      $display("FAIL reset_async: valid=%b instr=%h ready=%b count=%0d want 0/00000013/1/0",
               bus.InstrValidD, bus.InstrD, bus.InstrReadyF, bus.CountD);
    end
    mq.delete();
    m_stall = '0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    checks++;
    if (bus.InstrValidD !== 1'b0 || bus.CountD !== CW'(0)) begin
      errors++;
      $display("FAIL reset_drop: valid=%b count=%0d want 0/0", bus.InstrValidD, bus.CountD);
    end
  endtask

  task automatic test_predecode();
    logic [31:0] pi [6] = '{32'h00A00093, 32'h00112023, 32'hFE000EE3,
                            32'h0080006F, 32'h000012B7, 32'h1005252F};
    logic [2:0]  pf [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
    set_in(1'b1, pi[0], 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if (bus.InstrD !== pi[i] || bus.ImmSrcD !== pf[i] || bus.InstrValidD !== 1'b1) begin
        errors++;
        $display("FAIL predecode[%0d]: instr=%h imm=%b valid=%b want %h/%b/1",
                 i, bus.InstrD, bus.ImmSrcD, bus.InstrValidD, pi[i], pf[i]);
      end
      if (i < 5) set_in(1'b1, pi[i+1], 1'b0, 1'b0);
      else       set_in(1'b0, 32'h0, 1'b0, 1'b0);
    end
    cycle();
    checks++;
    if (bus.InstrValidD !== 1'b0 || bus.ImmSrcD !== 3'b000 || bus.InstrD !== NOP) begin
      errors++;
      $display("FAIL predecode_drain: valid=%b imm=%b instr=%h want 0/000/00000013",
               bus.InstrValidD, bus.ImmSrcD, bus.InstrD);
    end
  endtask

  task automatic test_full();
    logic [31:0] a = 32'h00500113, b = 32'h00212223, c = 32'h00C0006F;
    set_in(1'b1, a, 1'b1, 1'b0);
    cycle();
    set_in(1'b1, b, 1'b1, 1'b0);
    cycle();
    checks++;
    if (bus.InstrReadyF !== 1'b0 || bus.CountD !== CW'(2) || bus.InstrD !== a) begin
      errors++;
      $display("FAIL full_fill: ready=%b count=%0d head=%h want 0/2/%h",
               bus.InstrReadyF, bus.CountD, bus.InstrD, a);
    end
    set_in(1'b1, c, 1'b1, 1'b0);
    cycle();
    checks++;
    if (bus.InstrReadyF !== 1'b0 || bus.CountD !== CW'(2) || bus.InstrD !== a) begin
      errors++;
      $display("FAIL full_hold: ready=%b count=%0d head=%h want 0/2/%h",
               bus.InstrReadyF, bus.CountD, bus.InstrD, a);
    end
    set_in(1'b1, c, 1'b0, 1'b0);
    cycle();
    checks++;
    if (bus.CountD !== CW'(1) || bus.InstrD !== b || bus.InstrReadyF !== 1'b1) begin
      errors++;
      $display("FAIL full_norefill: count=%0d head=%h ready=%b want 1/%h/1",
               bus.CountD, bus.InstrD, bus.InstrReadyF, b);
    end
    cycle();
    checks++;
    if (bus.CountD !== CW'(1) || bus.InstrD !== c || bus.ImmSrcD !== 3'b011) begin
      errors++;
      $display("FAIL full_order: count=%0d head=%h imm=%b want 1/%h/011",
               bus.CountD, bus.InstrD, bus.ImmSrcD, c);
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    cycle();
    checks++;
    if (bus.CountD !== CW'(0) || bus.InstrValidD !== 1'b0) begin
      errors++;
      $display("FAIL full_empty: count=%0d valid=%b want 0/0", bus.CountD, bus.InstrValidD);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] x = 32'h000022B7, y = 32'h00208463;
    set_in(1'b1, x, 1'b0, 1'b0);
    cycle();
    set_in(1'b1, y, 1'b0, 1'b0);
    cycle();
    checks++;
    if (bus.CountD !== CW'(1) || bus.InstrD !== y || bus.ImmSrcD !== 3'b010) begin
      errors++;
      $display("FAIL simul: count=%0d head=%h imm=%b want 1/%h/010",
               bus.CountD, bus.InstrD, bus.ImmSrcD, y);
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    cycle();
  endtask

  task automatic test_flush();
    set_in(1'b1, 32'h00A00093, 1'b1, 1'b0);
    cycle();
    set_in(1'b1, 32'h00112023, 1'b1, 1'b0);
    cycle();
    set_in(1'b1, 32'h0080006F, 1'b0, 1'b1);
    cycle();
    checks++;
    if (bus.CountD !== CW'(0) || bus.InstrValidD !== 1'b0 || bus.InstrD !== NOP ||
        bus.InstrReadyF !== 1'b1) begin
      errors++;
      $display("FAIL flush: count=%0d valid=%b instr=%h ready=%b want 0/0/00000013/1",
               bus.CountD, bus.InstrValidD, bus.InstrD, bus.InstrReadyF);
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    cycle();
    checks++;
    if (bus.CountD !== CW'(0) || bus.InstrValidD !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: count=%0d valid=%b want 0/0", bus.CountD, bus.InstrValidD);
    end
  endtask

`ifdef DECQ_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    checks++;
    if (bus.StallCntD !== 32'd0) begin
      errors++;
      $display("FAIL stallcnt_reset: got %0d want 0", bus.StallCntD);
    end
    set_in(1'b1, 32'h00A00093, 1'b1, 1'b0);
    cycle();
    set_in(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (5) cycle();
    set_in(1'b0, 32'h0, 1'b1, 1'b1);
    cycle();
    checks++;
    if (bus.StallCntD !== 32'd5) begin
      errors++;
      $display("FAIL stallcnt: got %0d want 5", bus.StallCntD);
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_random();
    logic [6:0]  ops [11] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                              7'b1101111, 7'b0110111, 7'b0010111, 7'b0101111, 7'b0001111,
                              7'b0110011};
    logic [31:0] r;
    logic [31:0] exp_i;
    logic [2:0]  exp_f;
    logic [CW-1:0] exp_c;
    int bad;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      if ($urandom_range(0, 9) < 8) r[6:0] = ops[$urandom_range(0, 10)];
      if (r[6:0] == 7'b0001111 && $urandom_range(0, 1) == 1) r[14:12] = 3'b010;
      set_in($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
      cycle();
      exp_c = CW'(mq.size());
      exp_i = (mq.size() > 0) ? mq[0] : NOP;
      exp_f = (mq.size() > 0) ? ref_fmt(mq[0]) : 3'b000;
      checks++;
      if (bus.CountD !== exp_c || bus.InstrValidD !== (mq.size() > 0) ||
          bus.InstrReadyF !== (mq.size() < DEPTH) || bus.InstrD !== exp_i ||
          bus.ImmSrcD !== exp_f) begin
        errors++;
        if (bad < 10)
          $display("FAIL random[%0d]: count=%0d instr=%h imm=%b ready=%b valid=%b want %0d/%h/%b",
                   n, bus.CountD, bus.InstrD, bus.ImmSrcD, bus.InstrReadyF, bus.InstrValidD,
                   exp_c, exp_i, exp_f);
        bad++;
      end
`ifdef DECQ_STALL_CNT_EN
      checks++;
      if (bus.StallCntD !== m_stall) begin
        errors++;
        if (bad < 10) $display("FAIL random_stallcnt[%0d]: got %0d want %0d", n, bus.StallCntD, m_stall);
        bad++;
      end
`endif
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_predecode();
    test_full();
    test_simultaneous();
    test_flush();
`ifdef DECQ_STALL_CNT_EN
    test_stall_cnt();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
